// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin N-master byte bus arbiter with RAM/IO decode.
// Grant locking is built only when MEMBUS_ARB_LOCK_EN is defined.
module mem_bus_arbiter #(
    parameter int N_MASTERS      = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int LOCK_MAX       = 8
) (
    input  logic                            clk_in,
    input  logic                            rst_n_in,
    input  logic                            pause_in,
    input  logic [N_MASTERS-1:0]            m_req_in,
    input  logic [N_MASTERS-1:0]            m_lock_in,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0] m_a_in,
    input  logic [N_MASTERS-1:0]            m_wr_in,
    input  logic [N_MASTERS*8-1:0]          m_dout_in,
    output logic [N_MASTERS-1:0]            m_gnt_out,
    output logic [N_MASTERS-1:0]            m_rvalid_out,
    output logic [7:0]                      m_din_out,
    output logic                            ram_en_out,
    output logic                            ram_wr_out,
    output logic [RAM_ADDR_WIDTH-1:0]       ram_a_out,
    output logic [7:0]                      ram_d_out,
    input  logic [7:0]                      ram_d_in,
    output logic                            io_en_out,
    output logic                            io_wr_out,
    output logic [2:0]                      io_sel_out,
    output logic [7:0]                      io_d_out,
    input  logic [7:0]                      io_d_in,
    input  logic                            io_full_in
);
    localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    logic [N_MASTERS-1:0]  is_io;
    logic [N_MASTERS-1:0]  elig;
    logic [IW-1:0]         rr_ptr;
    logic [IW-1:0]         g_idx;
    logic [IW-1:0]         scan_idx;
    logic                  any_gnt;
    logic                  lock_hit;
    logic [IW-1:0]         lock_idx;
    logic [ADDR_WIDTH-1:0] sel_a;
    logic                  sel_wr;
    logic                  sel_io;
    logic [7:0]            sel_d;
    logic [N_MASTERS-1:0]  rvalid_q;
    logic                  src_q;
    logic                  unused_ok;

    always_comb begin
        is_io = '0;
        elig  = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            is_io[i] = (m_a_in[i*ADDR_WIDTH + RAM_ADDR_WIDTH - 1 +: 2] == 2'b11);
            elig[i]  = m_req_in[i] & ~pause_in
                     & ~(is_io[i] & m_wr_in[i] & io_full_in);
        end
    end

`ifdef MEMBUS_ARB_LOCK_EN
    localparam int CW = $clog2(LOCK_MAX + 1);

    logic          lock_v;
    logic [IW-1:0] lock_g;
    logic [CW-1:0] lock_cnt;

    assign lock_idx = lock_g;
    assign lock_hit = lock_v && (lock_cnt < CW'(LOCK_MAX)) && elig[lock_g];

    // Any idle cycle breaks a lock chain; only consecutive grants count.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            lock_v   <= 1'b0;
            lock_g   <= '0;
            lock_cnt <= '0;
        end else if (!any_gnt) begin
            lock_v   <= 1'b0;
            lock_cnt <= '0;
        end else if (lock_hit) begin
            lock_v   <= m_lock_in[g_idx];
            lock_cnt <= lock_cnt + 1'b1;
        end else begin
            lock_v   <= m_lock_in[g_idx];
            lock_g   <= g_idx;
            lock_cnt <= m_lock_in[g_idx] ? CW'(1) : '0;
        end
    end
`else
    assign lock_idx = '0;
    assign lock_hit = 1'b0;
`endif

    // Descending scan so the first eligible master after rr_ptr wins.
    always_comb begin
        any_gnt  = 1'b0;
        g_idx    = '0;
        scan_idx = '0;
        for (int k = N_MASTERS - 1; k >= 0; k--) begin
            scan_idx = IW'((int'(rr_ptr) + k) % N_MASTERS);
            if (elig[scan_idx]) begin
                any_gnt = 1'b1;
                g_idx   = scan_idx;
            end
        end
        if (lock_hit) begin
            any_gnt = 1'b1;
            g_idx   = lock_idx;
        end
    end

    assign m_gnt_out = any_gnt ? (N_MASTERS'(1) << g_idx) : '0;
    assign sel_a     = m_a_in[int'(g_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_d     = m_dout_in[int'(g_idx)*8 +: 8];
    assign sel_wr    = m_wr_in[g_idx];
    assign sel_io    = is_io[g_idx];

    always_comb begin
        ram_en_out = any_gnt & ~sel_io;
        ram_wr_out = ram_en_out & sel_wr;
        ram_a_out  = ram_en_out ? sel_a[RAM_ADDR_WIDTH-1:0] : '0;
        ram_d_out  = ram_en_out ? sel_d : '0;
        io_en_out  = any_gnt & sel_io;
        io_wr_out  = io_en_out & sel_wr;
        io_sel_out = io_en_out ? sel_a[2:0] : '0;
        io_d_out   = io_en_out ? sel_d : '0;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rr_ptr   <= '0;
            rvalid_q <= '0;
            src_q    <= 1'b0;
        end else begin
            rvalid_q <= sel_wr ? '0 : m_gnt_out;
            if (any_gnt) begin
                src_q <= sel_io;
                if (!lock_hit) begin
                    rr_ptr <= IW'((int'(g_idx) + 1) % N_MASTERS);
                end
            end
        end
    end

    assign m_rvalid_out = rvalid_q;
    assign m_din_out    = src_q ? io_d_in : ram_d_in;
    assign unused_ok    = ^{sel_a, m_lock_in};

endmodule
